dc_stage: RTL
=============

DC_STAGE -- requirements
Module: dc_stage

Interface
REQ-001 SHALL have parameter DC_TO_WB_WD, default 70, meaning width of dc_to_wb_bus: {pc[31:0], rf_we, rf_waddr[4:0], rf_wdata[31:0]}.
REQ-002 SHALL have port clk  input  1  clock; all state updates on posedge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port flush  input  1  exception flush; kills the held instruction.
REQ-005 SHALL have port stall  input  `StallBus  pipeline stall vector; uses bit 5 (this stage) and bit 6 (wb).
REQ-006 SHALL have port dt_to_dc_bus  input  `DT_TO_DC_WD  upstream payload: pc, mem_op[2:0], rf_we, rf_waddr[4:0], addr[31:0] (ex result), rt_old[31:0]; offsets from shared defines.
REQ-007 SHALL have port data_sram_rdata  input  32  load data from dcache.
REQ-008 SHALL have port data_sram_data_ok  input  1  one-cycle pulse, rdata valid.
REQ-009 SHALL have port dc_to_wb_bus  output  DC_TO_WB_WD  registered-stage result to wb.
REQ-010 SHALL have port dc_fwd_bus  output  38  {rf_we, rf_waddr, rf_wdata} bypass to id; rf_we forced 0 while load data not yet available.
REQ-011 SHALL have port stallreq_dc  output  1  request to stall stages 0-5.

Function
REQ-012 mem_op encoding SHALL be: 0 none, 1 lb, 2 lbu, 3 lh, 4 lhu, 5 lw, 6 lwl, 7 lwr.
REQ-013 Input register SHALL load dt_to_dc_bus when stall[5]=NoStop, load zero (bubble) when stall[5]=Stop and stall[6]=NoStop, and hold otherwise.
REQ-014 FSM states SHALL be IDLE, WAIT, HOLD.
REQ-015 IDLE: held mem_op!=0 and data_ok=0 -> WAIT; mem_op!=0 and data_ok=1 -> capture rdata into rbuf, go HOLD if stall[5]=Stop else stay IDLE.
REQ-016 WAIT: stallreq_dc=1; data_ok=1 -> capture rbuf; go HOLD if stall[5]=Stop after this cycle's request drops, else IDLE.
REQ-017 HOLD: use rbuf, ignore further data_ok; exit to IDLE on first cycle with stall[5]=NoStop.
REQ-018 stallreq_dc SHALL be combinational: 1 iff (state=WAIT or (state=IDLE, mem_op!=0)) and data_ok=0.
REQ-019 Load data source SHALL be data_sram_rdata in the data_ok cycle, rbuf in HOLD.
REQ-020 Byte lane SHALL be addr[1:0]; lb/lbu select byte lane, sign/zero extend to 32; lh/lhu select half addr[1], extend; lw passes 32 bits.
REQ-021 Non-load (mem_op=0): rf_wdata SHALL equal addr field, zero latency, stallreq_dc=0.
REQ-022 dc_to_wb_bus SHALL be combinational from held register plus aligned data; pc=0 and rf_we=0 for bubbles.
REQ-023 flush SHALL clear the input register, rbuf and force IDLE next cycle regardless of state; a data_ok arriving the same cycle is dropped.
REQ-024 Misaligned addresses SHALL not be checked here (ex raises AdEL).

Reset
REQ-025 rst SHALL zero input register, rbuf, dc_to_wb_bus fields, dc_fwd_bus, stallreq_dc, and set state IDLE; rst dominates flush and stall.

Configuration
REQ-026 Macro DC_LWLR_EN defined: mem_op 6/7 merge rdata with rt_old per addr[1:0] (lwl keeps rt_old low 3-addr bytes, lwr keeps high addr bytes, MIPS little-endian).
REQ-027 Macro DC_LWLR_EN undefined: mem_op 6/7 SHALL behave as lw; no merge logic generated.

Structure
REQ-028 mem_op codes, FSM state encodings, DC_TO_WB_WD and bus field offsets SHALL live in lib/defines.vh.
REQ-029 Alignment/extension SHALL be one sub-module dc_load_align (combinational: mem_op, addr[1:0], rdata, rt_old -> wdata).

Verification
REQ-030 lb addr=0x...3, rdata=0x80FF_1234, data_ok same cycle -> wdata=0xFFFF_FF80, stallreq_dc never 1.
REQ-031 lhu addr=0x...2, data_ok 3 cycles late -> stallreq_dc=1 for 3 cycles, WAIT, then wdata=0x0000_80FF.
REQ-032 lw data_ok while stall[6]=Stop for 2 cycles -> HOLD 2 cycles, rbuf=rdata kept, output unchanged on exit.
REQ-033 flush during WAIT with data_ok same cycle -> next cycle IDLE, dc_to_wb_bus rf_we=0, stallreq_dc=0.
REQ-034 DC_LWLR_EN: lwl addr=0x...1, rdata=0xAABBCCDD, rt_old=0x11223344 -> 0xCCDD3344; undefined -> 0xAABBCCDD.
REQ-035 rst asserted in WAIT -> all outputs 0, state IDLE next cycle.

Source files
------------

// File: rtl/dc_stage_pkg.sv
// Shared constants for the data-cache stage: bus layouts, mem_op codes, stall bits, FSM states.
package dc_stage_pkg;

  localparam int STALL_WD     = 8;
  localparam int DC_STALL_BIT = 5;
  localparam int WB_STALL_BIT = 6;
  localparam logic STOP       = 1'b1;
  localparam logic NO_STOP    = 1'b0;

  // dt_to_dc_bus = {pc, mem_op, rf_we, rf_waddr, addr, rt_old}, MSB first
  localparam int DT_TO_DC_WD = 105;
  localparam int RT_OLD_LSB  = 0;
  localparam int ADDR_LSB    = 32;
  localparam int WADDR_LSB   = 64;
  localparam int RF_WE_BIT   = 69;
  localparam int MEM_OP_LSB  = 70;
  localparam int PC_LSB      = 73;

  localparam int DC_TO_WB_WD_DEF = 70;
  localparam int DC_FWD_WD       = 38;

  localparam logic [2:0] OP_NONE = 3'd0;
  localparam logic [2:0] OP_LB   = 3'd1;
  localparam logic [2:0] OP_LBU  = 3'd2;
  localparam logic [2:0] OP_LH   = 3'd3;
  localparam logic [2:0] OP_LHU  = 3'd4;
  localparam logic [2:0] OP_LW   = 3'd5;
  localparam logic [2:0] OP_LWL  = 3'd6;
  localparam logic [2:0] OP_LWR  = 3'd7;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

endpackage

// File: rtl/dc_load_align.sv
// Load data alignment and extension. With DC_LWLR_EN defined, lwl/lwr merge with rt_old;
// otherwise they return the full word like lw.
module dc_load_align
  import dc_stage_pkg::*;
(
  input  logic [2:0]  mem_op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  input  logic [31:0] rt_old,
  output logic [31:0] wdata
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{addr_lo, 3'b000} +: 8];
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    wdata    = rdata;
    case (mem_op)
      OP_LB:  wdata = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU: wdata = {24'd0, byte_sel};
      OP_LH:  wdata = {{16{half_sel[15]}}, half_sel};
      OP_LHU: wdata = {16'd0, half_sel};
`ifdef DC_LWLR_EN
      // Little-endian unaligned word halves: lwl fills from the top, lwr from the bottom
      OP_LWL: begin
        case (addr_lo)
          2'd0:    wdata = {rdata[7:0],  rt_old[23:0]};
          2'd1:    wdata = {rdata[15:0], rt_old[15:0]};
          2'd2:    wdata = {rdata[23:0], rt_old[7:0]};
          default: wdata = rdata;
        endcase
      end
      OP_LWR: begin
        case (addr_lo)
          2'd0:    wdata = rdata;
          2'd1:    wdata = {rt_old[31:24], rdata[31:8]};
          2'd2:    wdata = {rt_old[31:16], rdata[31:16]};
          default: wdata = {rt_old[31:8],  rdata[31:24]};
        endcase
      end
`endif
      default: wdata = rdata;
    endcase
  end

`ifndef DC_LWLR_EN
  logic unused_rt_old;
  assign unused_rt_old = ^rt_old;
`endif

endmodule

// File: rtl/dc_stage.sv
// Data-cache stage: holds the instruction, waits for load data, aligns it and feeds wb/id.
// Optional lwl/lwr merging is enabled by defining DC_LWLR_EN.
module dc_stage
  import dc_stage_pkg::*;
#(
  parameter int DC_TO_WB_WD = DC_TO_WB_WD_DEF
)(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic [STALL_WD-1:0]    stall,
  input  logic [DT_TO_DC_WD-1:0] dt_to_dc_bus,
  input  logic [31:0]            data_sram_rdata,
  input  logic                   data_sram_data_ok,
  output logic [DC_TO_WB_WD-1:0] dc_to_wb_bus,
  output logic [DC_FWD_WD-1:0]   dc_fwd_bus,
  output logic                   stallreq_dc
);

  logic [DT_TO_DC_WD-1:0] dt_r;
  logic [1:0]  state, state_nxt;
  logic [31:0] rbuf;
  logic [31:0] pc, addr, rt_old, load_src, aligned, rf_wdata;
  logic [2:0]  mem_op;
  logic        rf_we, is_load, data_avail, capture;
  logic [4:0]  rf_waddr;

  always_ff @(posedge clk) begin
    if (rst || flush)
      dt_r <= '0;
    else if (stall[DC_STALL_BIT] == NO_STOP)
      dt_r <= dt_to_dc_bus;
    else if (stall[WB_STALL_BIT] == NO_STOP)
      dt_r <= '0;
  end

  assign pc       = dt_r[PC_LSB +: 32];
  assign mem_op   = dt_r[MEM_OP_LSB +: 3];
  assign rf_we    = dt_r[RF_WE_BIT];
  assign rf_waddr = dt_r[WADDR_LSB +: 5];
  assign addr     = dt_r[ADDR_LSB +: 32];
  assign rt_old   = dt_r[RT_OLD_LSB +: 32];
  assign is_load  = (mem_op != OP_NONE);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (is_load && !data_sram_data_ok)
          state_nxt = S_WAIT;
        else if (is_load && stall[DC_STALL_BIT] == STOP)
          state_nxt = S_HOLD;
      end
      S_WAIT: begin
        if (data_sram_data_ok)
          state_nxt = (stall[DC_STALL_BIT] == STOP) ? S_HOLD : S_IDLE;
      end
      S_HOLD: begin
        if (stall[DC_STALL_BIT] == NO_STOP)
          state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // rbuf keeps the returned word alive while the stage is frozen after data_ok
  assign capture = is_load && data_sram_data_ok && (state != S_HOLD);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state <= S_IDLE;
      rbuf  <= '0;
    end else begin
      state <= state_nxt;
      if (capture)
        rbuf <= data_sram_rdata;
    end
  end

  assign stallreq_dc = ((state == S_WAIT) || (state == S_IDLE && is_load)) && !data_sram_data_ok;
  assign load_src    = (state == S_HOLD) ? rbuf : data_sram_rdata;

  dc_load_align u_align (
    .mem_op  (mem_op),
    .addr_lo (addr[1:0]),
    .rdata   (load_src),
    .rt_old  (rt_old),
    .wdata   (aligned)
  );

  assign rf_wdata   = is_load ? aligned : addr;
  assign data_avail = !is_load || (state == S_HOLD) || data_sram_data_ok;

  assign dc_to_wb_bus = {pc, rf_we, rf_waddr, rf_wdata};
  assign dc_fwd_bus   = {rf_we & data_avail, rf_waddr, rf_wdata};

  logic unused_stall;
  assign unused_stall = ^{stall[STALL_WD-1:WB_STALL_BIT+1], stall[DC_STALL_BIT-1:0]};

endmodule
